// File: rtl/id_ex_stage_pkg.sv
// Shared definitions for the ID/EX stage: ALU-op encodings, funct3 codes and
// default datapath widths.
package id_ex_stage_pkg;

  localparam int unsigned DEF_XLEN = 32;
  localparam int unsigned DEF_RA_W = 5;

  localparam logic [1:0] ALUOP_LDST  = 2'b00;
  localparam logic [1:0] ALUOP_BR    = 2'b01;
  localparam logic [1:0] ALUOP_ARITH = 2'b10;
  localparam logic [1:0] ALUOP_JAL   = 2'b11;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SR   = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// Load-use hazard detection: flags an ID instruction that reads the
// destination of a load currently sitting in EX.
module id_ex_stage_hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned RA_W = DEF_RA_W
) (
  input  logic            id_valid,
  input  logic [1:0]      id_aluop,
  input  logic            id_i_type,
  input  logic            id_lui_flag,
  input  logic            id_memwrite,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic            ex_valid,
  input  logic            ex_memread,
  input  logic [RA_W-1:0] ex_rd,
  output logic            haz
);

  logic w_uses_rs1;
  logic w_uses_rs2;
  logic w_rd_nz;

  assign w_uses_rs1 = !(id_lui_flag | (id_aluop == ALUOP_JAL));
  // Stores read rs2 as write data even though their aluop is ld/st.
  assign w_uses_rs2 = !id_i_type & !id_lui_flag &
                      ((id_aluop == ALUOP_ARITH) | (id_aluop == ALUOP_BR) | id_memwrite);
  assign w_rd_nz    = (ex_rd != '0);

  assign haz = ex_valid & ex_memread & w_rd_nz & id_valid &
               ((w_uses_rs1 & (ex_rd == id_rs1)) | (w_uses_rs2 & (ex_rd == id_rs2)));

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register. Loads a bubble on flush or load-use hazard and
// raises stall to hold PC and IF/ID for the hazard cycle.
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int unsigned XLEN = DEF_XLEN,
  parameter int unsigned RA_W = DEF_RA_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            id_valid,
  input  logic [1:0]      id_aluop,
  input  logic [2:0]      id_funct3,
  input  logic            id_instr30,
  input  logic            id_i_type,
  input  logic            id_lui_flag,
  input  logic            id_regwrite,
  input  logic            id_memread,
  input  logic            id_memwrite,
  input  logic            id_memtoreg,
  input  logic            id_branch,
  input  logic            id_alusrc,
  input  logic [RA_W-1:0] id_rs1,
  input  logic [RA_W-1:0] id_rs2,
  input  logic [RA_W-1:0] id_rd,
  input  logic [XLEN-1:0] id_rs1_data,
  input  logic [XLEN-1:0] id_rs2_data,
  input  logic [XLEN-1:0] id_imm,
  input  logic [XLEN-1:0] id_pc,
  output logic            stall,
  output logic            ex_valid,
  output logic [1:0]      ex_aluop,
  output logic [2:0]      ex_funct3,
  output logic            ex_instr30,
  output logic            ex_i_type,
  output logic            ex_lui_flag,
  output logic            ex_regwrite,
  output logic            ex_memread,
  output logic            ex_memwrite,
  output logic            ex_memtoreg,
  output logic            ex_branch,
  output logic            ex_alusrc,
  output logic [RA_W-1:0] ex_rs1,
  output logic [RA_W-1:0] ex_rs2,
  output logic [RA_W-1:0] ex_rd,
  output logic [XLEN-1:0] ex_rs1_data,
  output logic [XLEN-1:0] ex_rs2_data,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc
);

  logic w_haz;
  logic w_bubble;
  logic w_ctl_en;

  id_ex_stage_hazard_detect #(
    .RA_W(RA_W)
  ) u_hazard_detect (
    .id_valid   (id_valid),
    .id_aluop   (id_aluop),
    .id_i_type  (id_i_type),
    .id_lui_flag(id_lui_flag),
    .id_memwrite(id_memwrite),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .haz        (w_haz)
  );

  assign stall    = w_haz & !flush;
  assign w_bubble = flush | w_haz;
  // Controls only pass for a real instruction that is not being squashed.
  assign w_ctl_en = id_valid & !w_bubble;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_aluop    <= '0;
      ex_funct3   <= '0;
      ex_instr30  <= 1'b0;
      ex_i_type   <= 1'b0;
      ex_lui_flag <= 1'b0;
      ex_regwrite <= 1'b0;
      ex_memread  <= 1'b0;
      ex_memwrite <= 1'b0;
      ex_memtoreg <= 1'b0;
      ex_branch   <= 1'b0;
      ex_alusrc   <= 1'b0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_pc       <= '0;
    end else begin
      ex_valid    <= w_ctl_en;
      ex_aluop    <= w_ctl_en ? id_aluop  : ALUOP_LDST;
      ex_funct3   <= w_ctl_en ? id_funct3 : F3_ADD;
      ex_instr30  <= w_ctl_en & id_instr30;
      ex_i_type   <= w_ctl_en & id_i_type;
      ex_lui_flag <= w_ctl_en & id_lui_flag;
      ex_regwrite <= w_ctl_en & id_regwrite;
      ex_memread  <= w_ctl_en & id_memread;
      ex_memwrite <= w_ctl_en & id_memwrite;
      ex_memtoreg <= w_ctl_en & id_memtoreg;
      ex_branch   <= w_ctl_en & id_branch;
      ex_alusrc   <= w_ctl_en & id_alusrc;
      ex_rs1      <= w_bubble ? '0 : id_rs1;
      ex_rs2      <= w_bubble ? '0 : id_rs2;
      ex_rd       <= w_bubble ? '0 : id_rd;
      ex_rs1_data <= w_bubble ? '0 : id_rs1_data;
      ex_rs2_data <= w_bubble ? '0 : id_rs2_data;
      ex_imm      <= w_bubble ? '0 : id_imm;
      ex_pc       <= w_bubble ? '0 : id_pc;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, load-use stalls, x0 rule, flush
// priority and invalid-instruction control gating.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        id_valid;
  logic [1:0]  id_aluop;
  logic [2:0]  id_funct3;
  logic        id_instr30, id_i_type, id_lui_flag;
  logic        id_regwrite, id_memread, id_memwrite, id_memtoreg, id_branch, id_alusrc;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [31:0] id_rs1_data, id_rs2_data, id_imm, id_pc;
  logic        stall, ex_valid;
  logic [1:0]  ex_aluop;
  logic [2:0]  ex_funct3;
  logic        ex_instr30, ex_i_type, ex_lui_flag;
  logic        ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, ex_branch, ex_alusrc;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [31:0] ex_rs1_data, ex_rs2_data, ex_imm, ex_pc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid),
    .id_aluop(id_aluop), .id_funct3(id_funct3), .id_instr30(id_instr30),
    .id_i_type(id_i_type), .id_lui_flag(id_lui_flag), .id_regwrite(id_regwrite),
    .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
    .id_branch(id_branch), .id_alusrc(id_alusrc), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rd(id_rd), .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
    .id_imm(id_imm), .id_pc(id_pc), .stall(stall), .ex_valid(ex_valid),
    .ex_aluop(ex_aluop), .ex_funct3(ex_funct3), .ex_instr30(ex_instr30),
    .ex_i_type(ex_i_type), .ex_lui_flag(ex_lui_flag), .ex_regwrite(ex_regwrite),
    .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_alusrc(ex_alusrc), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_rs1_data(ex_rs1_data), .ex_rs2_data(ex_rs2_data),
    .ex_imm(ex_imm), .ex_pc(ex_pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic id_clear();
    flush = 0; id_valid = 0; id_aluop = 0; id_funct3 = 0; id_instr30 = 0;
    id_i_type = 0; id_lui_flag = 0; id_regwrite = 0; id_memread = 0;
    id_memwrite = 0; id_memtoreg = 0; id_branch = 0; id_alusrc = 0;
    id_rs1 = 0; id_rs2 = 0; id_rd = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_imm = 0; id_pc = 0;
  endtask

  task automatic id_lw(input logic [4:0] rd, input logic [4:0] rs1);
    id_clear();
    id_valid = 1; id_aluop = 2'b00; id_funct3 = 3'b010; id_memread = 1;
    id_regwrite = 1; id_memtoreg = 1; id_alusrc = 1; id_rd = rd; id_rs1 = rs1;
  endtask

  task automatic id_add(input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2);
    id_clear();
    id_valid = 1; id_aluop = 2'b10; id_funct3 = 3'b000; id_regwrite = 1;
    id_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_pc = 32'h100;
  endtask

  // Advance one clock and settle just past the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    id_clear();
    rst = 1;
    // Reset holds everything at 0 even with live inputs present.
    id_valid = 1; id_regwrite = 1; id_aluop = 2'b10; id_rd = 5'd3; id_rs1_data = 32'hAAAA5555;
    tick();
    tick();
    chk("rst_ex_valid", 32'(ex_valid), 0);
    chk("rst_ex_regwrite", 32'(ex_regwrite), 0);
    chk("rst_ex_aluop", 32'(ex_aluop), 0);
    chk("rst_ex_rd", 32'(ex_rd), 0);
    chk("rst_ex_rs1_data", ex_rs1_data, 0);
    chk("rst_stall", 32'(stall), 0);
    @(negedge clk);
    rst = 0;
    tick();
    chk("post_rst_valid", 32'(ex_valid), 1);
    chk("post_rst_regwrite", 32'(ex_regwrite), 1);
    chk("post_rst_aluop", 32'(ex_aluop), 2);
    chk("post_rst_rd", 32'(ex_rd), 3);
    chk("post_rst_rs1_data", ex_rs1_data, 32'hAAAA5555);

    // Load-use on rs1: one-cycle stall, then the add is captured.
    id_lw(5'd5, 5'd1);
    tick();
    chk("lw_ex_memread", 32'(ex_memread), 1);
    chk("lw_ex_rd", 32'(ex_rd), 5);
    id_add(5'd6, 5'd5, 5'd7);
    #1;
    chk("lu_stall", 32'(stall), 1);
    tick();
    chk("lu_bubble_valid", 32'(ex_valid), 0);
    chk("lu_bubble_regwrite", 32'(ex_regwrite), 0);
    chk("lu_stall_cleared", 32'(stall), 0);
    tick();
    chk("lu_add_valid", 32'(ex_valid), 1);
    chk("lu_add_aluop", 32'(ex_aluop), 2);
    chk("lu_add_funct3", 32'(ex_funct3), 0);
    chk("lu_add_rd", 32'(ex_rd), 6);
    chk("lu_add_pc", ex_pc, 32'h100);
    chk("lu_add_no_stall", 32'(stall), 0);

    // addi with rs2 field matching the load target: rs2 unused, no stall.
    id_lw(5'd5, 5'd1);
    tick();
    id_clear();
    id_valid = 1; id_aluop = 2'b10; id_i_type = 1; id_alusrc = 1; id_regwrite = 1;
    id_rd = 5'd6; id_rs1 = 5'd0; id_rs2 = 5'd5; id_imm = 32'd5;
    #1;
    chk("addi_no_stall", 32'(stall), 0);
    tick();
    chk("addi_valid", 32'(ex_valid), 1);
    chk("addi_i_type", 32'(ex_i_type), 1);
    chk("addi_imm", ex_imm, 5);

    // Store data on rs2 does depend on the load.
    id_lw(5'd5, 5'd1);
    tick();
    id_clear();
    id_valid = 1; id_aluop = 2'b00; id_memwrite = 1; id_alusrc = 1;
    id_rs1 = 5'd2; id_rs2 = 5'd5;
    #1;
    chk("sw_rs2_stall", 32'(stall), 1);
    // LUI reads no sources.
    id_clear();
    id_valid = 1; id_aluop = 2'b10; id_lui_flag = 1; id_rs1 = 5'd5; id_rs2 = 5'd5; id_rd = 5'd9;
    #1;
    chk("lui_no_stall", 32'(stall), 0);

    // Load to x0 never stalls.
    id_lw(5'd0, 5'd1);
    tick();
    id_add(5'd1, 5'd0, 5'd0);
    #1;
    chk("x0_no_stall", 32'(stall), 0);
    tick();
    chk("x0_add_rd", 32'(ex_rd), 1);

    // Flush beats the hazard: no stall, bubble loaded.
    id_lw(5'd5, 5'd1);
    tick();
    id_add(5'd6, 5'd5, 5'd7);
    flush = 1;
    #1;
    chk("flush_no_stall", 32'(stall), 0);
    tick();
    chk("flush_valid", 32'(ex_valid), 0);
    chk("flush_regwrite", 32'(ex_regwrite), 0);
    chk("flush_rd", 32'(ex_rd), 0);

    // Invalid instruction: controls gated off.
    id_clear();
    id_memwrite = 1; id_regwrite = 1; id_rd = 5'd4;
    tick();
    chk("inv_valid", 32'(ex_valid), 0);
    chk("inv_memwrite", 32'(ex_memwrite), 0);
    chk("inv_regwrite", 32'(ex_regwrite), 0);

    // Back-to-back dependent loads stall only once.
    id_lw(5'd5, 5'd1);
    tick();
    id_lw(5'd6, 5'd5);
    #1;
    chk("b2b_stall", 32'(stall), 1);
    tick();
    chk("b2b_second_stall", 32'(stall), 0);
    tick();
    chk("b2b_lw2_rd", 32'(ex_rd), 6);
    chk("b2b_lw2_memread", 32'(ex_memread), 1);

    // Reset mid-stall clears at once; stall stays low afterwards.
    id_lw(5'd5, 5'd1);
    tick();
    id_add(5'd6, 5'd5, 5'd7);
    #1;
    chk("mid_stall_before", 32'(stall), 1);
    rst = 1;
    #1;
    chk("mid_rst_stall", 32'(stall), 0);
    chk("mid_rst_memread", 32'(ex_memread), 0);
    @(negedge clk);
    rst = 0;
    #1;
    chk("mid_rel_stall", 32'(stall), 0);
    tick();
    chk("mid_rel_add_valid", 32'(ex_valid), 1);
    chk("mid_rel_add_rd", 32'(ex_rd), 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
